// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx_arbiter block.
package uart_arb_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitDone,
    StHold
  } arb_state_t;

  // Width of the HOLD timeout counter, never narrower than one bit.
  function automatic int unsigned HOLD_CNT_W(input int unsigned hold_max);
    return (hold_max > 1) ? $clog2(hold_max) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority encoder: first valid requester at or after i_rr_ptr,
// wrapping modulo NUM_REQ.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] o_winner,
  output logic                       o_any_valid
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_rot;
  int unsigned        w_sum;
  logic               w_found;

  // Bit k of w_rot is requester (i_rr_ptr + k) mod NUM_REQ.
  assign w_rot = NUM_REQ'({i_req_valid, i_req_valid} >> i_rr_ptr);

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_sum    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = 32'(i_rr_ptr) + k;
        if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
        o_winner = PtrW'(w_sum);
      end
    end
  end

  assign o_any_valid = |i_req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte requesters.
// Define UART_TX_ARB_PKT_LOCK_EN to lock the grant per message with a HOLD_MAX timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned HOLD_MAX = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*8-1:0]       i_req_byte,
  input  logic [NUM_REQ-1:0]         i_req_last,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_tx_data_valid,
  output logic [7:0]                 o_tx_byte,
  input  logic                       i_tx_active,
  input  logic                       i_tx_done,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  arb_state_t         r_state;
  logic [PtrW-1:0]    r_rr_ptr, r_grant_id, w_winner, w_ptr_next;
  logic [7:0]         r_tx_byte, w_win_byte;
  logic [NUM_REQ-1:0] r_req_ready;
  logic               r_tx_dv, r_busy, w_any_valid;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .i_req_valid(i_req_valid),
    .i_rr_ptr   (r_rr_ptr),
    .o_winner   (w_winner),
    .o_any_valid(w_any_valid)
  );

  assign w_win_byte = i_req_byte[{w_winner, 3'b000} +: 8];
  assign w_ptr_next = (r_grant_id == PtrW'(NUM_REQ - 1)) ? '0 : r_grant_id + PtrW'(1);

`ifdef UART_TX_ARB_PKT_LOCK_EN
  localparam int unsigned CntW = HOLD_CNT_W(HOLD_MAX);

  logic [CntW-1:0] r_hold_cnt;
  logic            r_last, w_win_last, w_own_valid, w_own_last;
  logic [7:0]      w_own_byte;

  assign w_win_last  = i_req_last[w_winner];
  assign w_own_valid = i_req_valid[r_grant_id];
  assign w_own_last  = i_req_last[r_grant_id];
  assign w_own_byte  = i_req_byte[{r_grant_id, 3'b000} +: 8];
`else
  logic w_unused_lock;
  assign w_unused_lock = ^{i_req_last, HOLD_MAX};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_tx_byte   <= '0;
      r_req_ready <= '0;
      r_tx_dv     <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
      r_last      <= 1'b0;
      r_hold_cnt  <= '0;
`endif
    end else begin
      r_req_ready <= '0;
      r_tx_dv     <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // Guard on tx_active so a frame left running across reset is never overlapped.
          if (w_any_valid && !i_tx_active) begin
            r_grant_id  <= w_winner;
            r_tx_byte   <= w_win_byte;
            r_req_ready <= NUM_REQ'(1) << w_winner;
            r_tx_dv     <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= StLaunch;
`ifdef UART_TX_ARB_PKT_LOCK_EN
            r_last      <= w_win_last;
`endif
          end
        end
        StLaunch: r_state <= StWaitDone;
        StWaitDone: begin
          if (i_tx_done) begin
`ifdef UART_TX_ARB_PKT_LOCK_EN
            if (r_last) begin
              r_rr_ptr <= w_ptr_next;
              r_busy   <= 1'b0;
              r_state  <= StIdle;
            end else if (w_own_valid) begin
              r_tx_byte   <= w_own_byte;
              r_last      <= w_own_last;
              r_req_ready <= NUM_REQ'(1) << r_grant_id;
              r_tx_dv     <= 1'b1;
              r_state     <= StLaunch;
            end else begin
              r_hold_cnt <= '0;
              r_state    <= StHold;
            end
`else
            r_rr_ptr <= w_ptr_next;
            r_busy   <= 1'b0;
            r_state  <= StIdle;
`endif
          end
        end
`ifdef UART_TX_ARB_PKT_LOCK_EN
        StHold: begin
          if (w_own_valid) begin
            r_tx_byte   <= w_own_byte;
            r_last      <= w_own_last;
            r_req_ready <= NUM_REQ'(1) << r_grant_id;
            r_tx_dv     <= 1'b1;
            r_state     <= StLaunch;
          end else if (r_hold_cnt == CntW'(HOLD_MAX - 1)) begin
            r_rr_ptr <= w_ptr_next;
            r_busy   <= 1'b0;
            r_state  <= StIdle;
          end else begin
            r_hold_cnt <= r_hold_cnt + CntW'(1);
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready     = r_req_ready;
  assign o_tx_data_valid = r_tx_dv;
  assign o_tx_byte       = r_tx_byte;
  assign o_grant_id      = r_grant_id;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx and requester queues.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NR    = 3;
  localparam int HOLD  = 16;
  localparam int FRAME = 12;
  localparam int GW    = $clog2(NR);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR*8-1:0] req_byte = '0;
  logic [NR-1:0]   req_ready;
  logic            tx_dv;
  logic [7:0]      tx_byte;
  logic            tx_active = 1'b0;
  logic            tx_done = 1'b0;
  logic [GW-1:0]   grant_id;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_cnt = 0;
  logic [7:0] last_launched = '0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  typedef struct packed {
    logic [GW-1:0] id;
    logic [7:0]    b;
  } exp_t;
  exp_t sb_q[$];

  typedef struct packed {
    logic [2:0]  mask;
    logic [23:0] bytes;  // {b2, b1, b0}
    logic [5:0]  ord;    // {o2, o1, o0} expected grant order
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ (NR),
    .HOLD_MAX(HOLD)
  ) u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (req_valid),
    .i_req_byte     (req_byte),
    .i_req_last     (req_last),
    .o_req_ready    (req_ready),
    .o_tx_data_valid(tx_dv),
    .o_tx_byte      (tx_byte),
    .i_tx_active    (tx_active),
    .i_tx_done      (tx_done),
    .o_grant_id     (grant_id),
    .o_busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // uart_tx model: independent of the arbiter reset, like the real serializer.
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (tx_active) begin
      if (frame_cnt == FRAME - 1) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
      end else begin
        frame_cnt <= frame_cnt + 1;
      end
    end else if (tx_dv) begin
      tx_active <= 1'b1;
      frame_cnt <= 0;
    end
  end

  // Requesters: pop on the accept pulse, present the queue head on the falling edge.
  always @(posedge clk) begin
    if (req_ready[0] && q0.size() != 0) void'(q0.pop_front());
    if (req_ready[1] && q1.size() != 0) void'(q1.pop_front());
    if (req_ready[2] && q2.size() != 0) void'(q2.pop_front());
  end

  always @(negedge clk) begin
    req_valid = '0;
    req_last  = '0;
    req_byte  = '0;
    if (q0.size() != 0) begin req_valid[0] = 1'b1; {req_last[0], req_byte[7:0]}   = q0[0]; end
    if (q1.size() != 0) begin req_valid[1] = 1'b1; {req_last[1], req_byte[15:8]}  = q1[0]; end
    if (q2.size() != 0) begin req_valid[2] = 1'b1; {req_last[2], req_byte[23:16]} = q2[0]; end
  end

  // Scoreboard: every launch pops one expected {grant, byte}.
  always @(negedge clk) begin
    if (rst_n && tx_dv) begin
      exp_t e;
      check("launch_overlap", 32'(tx_active), 32'd0);
      check("req_ready_onehot", 32'(req_ready), 32'(NR'(1) << grant_id));
      check("busy_at_launch", 32'(busy), 32'd1);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_launch: got byte 0x%0h, expected no launch", tx_byte);
      end else begin
        e = sb_q.pop_front();
        check("tx_byte", 32'(tx_byte), 32'(e.b));
        check("grant_id", 32'(grant_id), 32'(e.id));
      end
      last_launched = tx_byte;
    end
    if (rst_n && tx_done && busy) check("tx_byte_stable", 32'(tx_byte), 32'(last_launched));
  end

  task automatic push_req(input int i, input logic [7:0] b, input logic last);
    case (i)
      0:       q0.push_back({last, b});
      1:       q1.push_back({last, b});
      default: q2.push_back({last, b});
    endcase
  endtask

  task automatic expect_tx(input int id, input logic [7:0] b);
    exp_t e;
    e.id = GW'(id);
    e.b  = b;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    while ((sb_q.size() != 0 || q0.size() != 0 || q1.size() != 0 || q2.size() != 0 ||
            busy || tx_active) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drain"}, 32'(k < limit), 32'd1);
  endtask

  task automatic wait_launch(input string name, input int limit);
    int k = 0;
    while (!tx_dv && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({name, "_launch_seen"}, 32'(k < limit), 32'd1);
  endtask

  initial begin
    int id;
    int overlap;
    vecs[0] = '{mask: 3'b100, bytes: 24'h55_00_00, ord: 6'b00_00_10};
    vecs[1] = '{mask: 3'b011, bytes: 24'h00_6A_42, ord: 6'b00_01_00};
    vecs[2] = '{mask: 3'b111, bytes: 24'h33_22_11, ord: 6'b01_00_10};
    vecs[3] = '{mask: 3'b101, bytes: 24'h5A_00_A5, ord: 6'b00_00_10};
    vecs[4] = '{mask: 3'b110, bytes: 24'h3C_C3_00, ord: 6'b00_10_01};

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_dv", 32'(tx_dv), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Single requester latency: pulse exactly in the cycle after the sampling edge.
    @(posedge clk);
    push_req(0, 8'h3F, 1'b1);
    expect_tx(0, 8'h3F);
    @(negedge clk);
    check("lat_pre_dv", 32'(tx_dv), 32'd0);
    @(negedge clk);
    check("lat_dv", 32'(tx_dv), 32'd1);
    check("lat_ready", 32'(req_ready), 32'b001);
    @(negedge clk);
    check("lat_dv_drop", 32'(tx_dv), 32'd0);
    check("lat_ready_drop", 32'(req_ready), 32'd0);
    check("lat_busy_hold", 32'(busy), 32'd1);
    wait_idle("single", 200);

    // Table of contention patterns; the rotation pointer carries over between entries.
    for (int v = 0; v < 5; v++) begin
      @(posedge clk);
      for (int r = 0; r < NR; r++)
        if (vecs[v].mask[r]) push_req(r, vecs[v].bytes[8*r +: 8], 1'b1);
      for (int j = 0; j < $countones(vecs[v].mask); j++) begin
        id = int'(vecs[v].ord[2*j +: 2]);
        expect_tx(id, vecs[v].bytes[8*id +: 8]);
      end
      wait_idle("vec", 400);
    end

    // Fairness: both continuously valid, grants must alternate 0,1,0,1,...
    @(posedge clk);
    for (int j = 0; j < 4; j++) begin
      push_req(0, 8'h10 + 8'(j), 1'b1);
      push_req(1, 8'h20 + 8'(j), 1'b1);
      expect_tx(0, 8'h10 + 8'(j));
      expect_tx(1, 8'h20 + 8'(j));
    end
    wait_idle("fair", 600);

    // Reset during WAIT_DONE, then no launch until the old frame ends.
    @(posedge clk);
    push_req(2, 8'h77, 1'b1);
    expect_tx(2, 8'h77);
    wait_launch("rst", 100);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_active", 32'(tx_active), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tx_byte", 32'(tx_byte), 32'd0);
    check("mid_rst_grant", 32'(grant_id), 32'd0);
    check("mid_rst_dv", 32'(tx_dv), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_req(2, 8'h98, 1'b1);
    push_req(0, 8'h99, 1'b1);
    expect_tx(0, 8'h99);
    expect_tx(2, 8'h98);
    overlap = 0;
    for (int k = 0; k < 40 && tx_active; k++) begin
      @(negedge clk);
      if (tx_dv && tx_active) overlap++;
    end
    check("post_rst_no_overlap", 32'(overlap), 32'd0);
    wait_idle("post_rst", 400);

`ifdef UART_TX_ARB_PKT_LOCK_EN
    // Message lock: req 0 waits until req 1's last byte.
    @(posedge clk);
    push_req(1, 8'hA1, 1'b0);
    push_req(1, 8'hA2, 1'b0);
    push_req(1, 8'hA3, 1'b1);
    expect_tx(1, 8'hA1);
    expect_tx(1, 8'hA2);
    expect_tx(1, 8'hA3);
    expect_tx(0, 8'hFF);
    wait_launch("lock", 100);
    @(posedge clk);
    push_req(0, 8'hFF, 1'b1);
    wait_idle("lock", 400);

    // HOLD expiry: owner stalls after a non-last byte, release after HOLD cycles.
    @(posedge clk);
    push_req(1, 8'hA4, 1'b0);
    expect_tx(1, 8'hA4);
    expect_tx(0, 8'hEE);
    wait_launch("hold", 100);
    @(posedge clk);
    push_req(0, 8'hEE, 1'b1);
    begin
      int k;
      k = 0;
      while (!tx_done && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("hold_done_seen", 32'(k < 100), 32'd1);
      k = 0;
      while (k < 60) begin
        @(negedge clk);
        k++;
        if (tx_dv) break;
      end
      check("hold_release_gap", 32'(k), 32'd18);
    end
    wait_idle("hold", 400);
`endif

    check("sb_empty_end", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
